// File: rtl/frame_scaler_downloader.sv
// frame_scaler_downloader: reads a stored frame from PSRAM in fixed bursts,
// decimates it (nearest neighbour, error accumulators) and streams marked
// pixels to the display FIFO.
// Ports: start/abort/base_addr control; read_rq/read_ack/read_addr/mem_rd_en
// and read_data/rd_data_valid to arbiter+memory; queue_data/wr_en/queue_full
// to the FIFO; busy/download_done status.
module frame_scaler_downloader #(
  parameter int PIXEL_W      = 16,
  parameter int MEMORY_BURST = 32,
  parameter int ADDR_W       = 21,
  parameter int SRC_WIDTH    = 640,
  parameter int SRC_HEIGHT   = 480,
  parameter int DST_WIDTH    = 480,
  parameter int DST_HEIGHT   = 272
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              queue_full,
  output logic [PIXEL_W:0]  queue_data,
  output logic              wr_en,
  output logic              read_rq,
  input  logic              read_ack,
  output logic [ADDR_W-1:0] read_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       read_data,
  input  logic              rd_data_valid,
  output logic              busy,
  output logic              download_done
);
  localparam int PPW  = 32 / PIXEL_W;
  localparam int BW   = MEMORY_BURST / PPW;
  localparam int SMAX = SRC_WIDTH > SRC_HEIGHT ? SRC_WIDTH : SRC_HEIGHT;
  localparam int AW   = $clog2(SMAX) + 1;
  localparam int WCW  = BW > 1 ? $clog2(BW) : 1;
  localparam int PCW  = MEMORY_BURST > 1 ? $clog2(MEMORY_BURST) : 1;
  localparam int SH   = $clog2(PPW);
  localparam int PSH  = $clog2(PIXEL_W);

  localparam logic [ADDR_W-1:0] LSTEP = ADDR_W'(SRC_WIDTH);
  localparam logic [ADDR_W-1:0] BSTEP = ADDR_W'(MEMORY_BURST);
  localparam logic [AW-1:0] SW = AW'(SRC_WIDTH);
  localparam logic [AW-1:0] SHG = AW'(SRC_HEIGHT);
  localparam logic [AW-1:0] DW = AW'(DST_WIDTH);
  localparam logic [AW-1:0] DH = AW'(DST_HEIGHT);
  localparam logic [PIXEL_W:0] M_SOF = {1'b1, {PIXEL_W{1'b0}}};
  localparam logic [PIXEL_W:0] M_SOL = {1'b1, PIXEL_W'(1)};
  localparam logic [PIXEL_W:0] M_EOF = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ROW, S_SOL, S_REQ,
    S_WAIT, S_FILL, S_DRAIN, S_EOF, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] burst_addr;
  logic [AW-1:0]     row;
  logic [AW-1:0]     ev;
  logic [AW-1:0]     eh;
  logic [WCW-1:0]    wcnt;
  logic [PCW-1:0]    pcnt;
  logic              pend;
  logic              aborting;
  logic [31:0]       cache [BW];

  logic              gate;
  logic              free;
  logic              keep;
  logic [AW-1:0]     eh_nx;
  logic [AW-1:0]     ev_nx;
  logic [WCW-1:0]    widx;
  logic [SH-1:0]     lane;
  logic [4:0]        bofs;
  logic [31:0]       cur_word;
  logic [PIXEL_W-1:0] pix;
  logic [ADDR_W-1:0] next_burst;
  logic [ADDR_W-1:0] line_end;

  // abort blocks writes at once, except the closing EOF
  assign gate = abort && state != S_IDLE
             && state != S_EOF && state != S_DONE;
  assign wr_en = pend && !queue_full && !gate;
  // output slot usable this cycle
  assign free = !pend || wr_en;

  assign eh_nx = eh + DW;
  assign keep  = eh_nx >= SW;
  assign ev_nx = ev + DH;

  assign widx     = WCW'(pcnt >> SH);
  assign lane     = pcnt[SH-1:0];
  assign bofs     = {lane, {PSH{1'b0}}};
  assign cur_word = cache[widx];
  assign pix      = cur_word[bofs +: PIXEL_W];

  assign next_burst = burst_addr + BSTEP;
  assign line_end   = line_addr + LSTEP;

  always_ff @(posedge clk) begin
    if (state == S_FILL && rd_data_valid) cache[wcnt] <= read_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      line_addr     <= '0;
      burst_addr    <= '0;
      row           <= '0;
      ev            <= '0;
      eh            <= '0;
      wcnt          <= '0;
      pcnt          <= '0;
      pend          <= 1'b0;
      aborting      <= 1'b0;
      queue_data    <= '0;
      read_rq       <= 1'b0;
      read_addr     <= '0;
      mem_rd_en     <= 1'b0;
      busy          <= 1'b0;
      download_done <= 1'b0;
    end else begin
      mem_rd_en     <= 1'b0;
      download_done <= 1'b0;
      if (wr_en) pend <= 1'b0;
      // a granted burst must still be drained from the memory
      if (gate && state != S_FILL
          && !(state == S_WAIT && read_ack)) begin
        pend     <= 1'b0;
        aborting <= 1'b1;
        read_rq  <= 1'b0;
        state    <= S_EOF;
      end else begin
        if (gate) begin
          pend     <= 1'b0;
          aborting <= 1'b1;
        end
        unique case (state)
          S_IDLE: if (start) begin
            line_addr <= base_addr;
            row       <= '0;
            ev        <= '0;
            busy      <= 1'b1;
            aborting  <= 1'b0;
            state     <= S_SOF;
          end
          S_SOF: if (free) begin
            queue_data <= M_SOF;
            pend       <= 1'b1;
            state      <= S_ROW;
          end
          S_ROW: begin
            if (row == SHG) begin
              state <= S_EOF;
            end else if (ev_nx >= SHG) begin
              ev    <= ev_nx - SHG;
              state <= S_SOL;
            end else begin
              ev        <= ev_nx;
              line_addr <= line_end;
              row       <= row + AW'(1);
            end
          end
          S_SOL: if (free) begin
            queue_data <= M_SOL;
            pend       <= 1'b1;
            eh         <= '0;
            burst_addr <= line_addr;
            state      <= S_REQ;
          end
          S_REQ: begin
            read_rq   <= 1'b1;
            read_addr <= burst_addr;
            state     <= S_WAIT;
          end
          S_WAIT: if (read_ack) begin
            mem_rd_en <= 1'b1;
            wcnt      <= '0;
            state     <= S_FILL;
          end
          S_FILL: if (rd_data_valid) begin
            if (wcnt == WCW'(BW - 1)) begin
              read_rq <= 1'b0;
              pcnt    <= '0;
              state   <= (aborting || abort) ? S_EOF : S_DRAIN;
            end else begin
              wcnt <= wcnt + WCW'(1);
            end
          end
          S_DRAIN: if (!keep || free) begin
            eh <= keep ? eh_nx - SW : eh_nx;
            if (keep) begin
              queue_data <= {1'b0, pix};
              pend       <= 1'b1;
            end
            if (pcnt == PCW'(MEMORY_BURST - 1)) begin
              burst_addr <= next_burst;
              if (next_burst != line_end) begin
                state <= S_REQ;
              end else begin
                line_addr <= line_end;
                row       <= row + AW'(1);
                state     <= S_ROW;
              end
            end else begin
              pcnt <= pcnt + PCW'(1);
            end
          end
          S_EOF: if (free) begin
            queue_data <= M_EOF;
            pend       <= 1'b1;
            state      <= S_DONE;
          end
          S_DONE: if (!pend || wr_en) begin
            download_done <= 1'b1;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
